// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: ALU ops, B-shift codes, FSM states and status flag bits.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OpAdd  = 2'b00,
        OpSub  = 2'b01,
        OpAnd  = 2'b10,
        OpNotB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ShNone       = 2'b00,
        ShLeft       = 2'b01,
        ShRightLogic = 2'b10,
        ShRightArith = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StExec,
        StResp
    } state_e;

    localparam int unsigned Z_BIT = 0;
    localparam int unsigned N_BIT = 1;
    localparam int unsigned V_BIT = 2;

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU core: add, sub, and, not-B, plus a zero flag.
module alu_sequencer_alu
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] Ain,
    input  logic [DATA_W-1:0] Bin,
    input  logic [1:0]        ALUop,
    output logic [DATA_W-1:0] out,
    output logic              Z
);

    always_comb begin
        out = '0;
        unique case (ALUop)
            OpAdd:   out = Ain + Bin;
            OpSub:   out = Ain + ~Bin + DATA_W'(1);
            OpAnd:   out = Ain & Bin;
            OpNotB:  out = ~Bin;
            default: out = '0;
        endcase
    end

    assign Z = (out == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Five-state sequencer around the ALU core: accept, load A, load B, execute, respond.
// Optional build macro ALU_SEQ_SHIFT_EN enables the B-operand shifter in LOAD_B.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [1:0]        req_shift,
    input  logic              req_wr_status,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [2:0]        status,
    output logic              busy
);

    state_e            r_state;
    state_e            w_state_next;
    alu_op_e           r_op;
    logic              r_wr_status;
    logic [DATA_W-1:0] r_b_lat;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic [2:0]        r_status;
    logic [DATA_W-1:0] w_b_shifted;
    logic [DATA_W-1:0] w_alu_out;
    logic              w_alu_z;
    logic              w_v;
    logic [2:0]        w_flags;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (req_valid) w_state_next = StLoadA;
            StLoadA: w_state_next = StLoadB;
            StLoadB: w_state_next = StExec;
            StExec:  w_state_next = StResp;
            StResp:  if (resp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_op        <= OpAdd;
            r_wr_status <= 1'b0;
            r_b_lat     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_status    <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_op        <= alu_op_e'(req_op);
                        r_b_lat     <= req_b;
                        r_wr_status <= req_wr_status;
                    end
                end
                StLoadA: r_a <= req_a;
                StLoadB: r_b <= w_b_shifted;
                StExec: begin
                    r_c <= w_alu_out;
                    if (r_wr_status) r_status <= w_flags;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_SHIFT_EN
    shift_e r_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= ShNone;
        end else if (r_state == StIdle && req_valid) begin
            r_shift <= shift_e'(req_shift);
        end
    end

    always_comb begin
        w_b_shifted = r_b_lat;
        unique case (r_shift)
            ShNone:       w_b_shifted = r_b_lat;
            ShLeft:       w_b_shifted = {r_b_lat[DATA_W-2:0], 1'b0};
            ShRightLogic: w_b_shifted = {1'b0, r_b_lat[DATA_W-1:1]};
            ShRightArith: w_b_shifted = {r_b_lat[DATA_W-1], r_b_lat[DATA_W-1:1]};
            default:      w_b_shifted = r_b_lat;
        endcase
    end
`else
    logic w_unused_shift;
    assign w_unused_shift = ^req_shift;
    assign w_b_shifted    = r_b_lat;
`endif

    alu_sequencer_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .Ain   (r_a),
        .Bin   (r_b),
        .ALUop (r_op),
        .out   (w_alu_out),
        .Z     (w_alu_z)
    );

    // Signed overflow from operand/result sign bits; logical ops never overflow.
    always_comb begin
        w_v = 1'b0;
        unique case (r_op)
            OpAdd: w_v = (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                         (w_alu_out[DATA_W-1] != r_a[DATA_W-1]);
            OpSub: w_v = (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                         (w_alu_out[DATA_W-1] != r_a[DATA_W-1]);
            default: w_v = 1'b0;
        endcase
    end

    always_comb begin
        w_flags        = '0;
        w_flags[Z_BIT] = w_alu_z;
        w_flags[N_BIT] = w_alu_out[DATA_W-1];
        w_flags[V_BIT] = w_v;
    end

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = (r_state == StResp);
    assign busy       = (r_state != StIdle);
    assign resp_data  = r_c;
    assign status     = r_status;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases, random ops against an arithmetic model,
// response stalls and mid-operation reset. Shift cases are active when ALU_SEQ_SHIFT_EN is set.
module tb_alu_sequencer;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic [1:0]    req_shift = 2'b00;
    logic          req_wr_status = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  resp_data;
    logic [2:0]    status;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] m_status = 3'b000;

    always #5 clk = ~clk;

    alu_sequencer #(
        .DATA_W (W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_shift     (req_shift),
        .req_wr_status (req_wr_status),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .status        (status),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] m_shift(input logic [W-1:0] b, input logic [1:0] sh);
        logic [W-1:0] r;
        r = b;
`ifdef ALU_SEQ_SHIFT_EN
        case (sh)
            2'b01:   r = b * 2;
            2'b10:   r = b / 2;
            2'b11:   r = (b / 2) | (b & 16'h8000);
            default: r = b;
        endcase
`else
        if (sh == 2'b11) r = b;
`endif
        return r;
    endfunction

    // Reference result and flags from plain integer arithmetic on signed interpretations.
    task automatic m_calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic [2:0] flags);
        int sa;
        int sb;
        int s;
        logic v;
        sa = $signed(a);
        sb = $signed(b);
        v  = 1'b0;
        case (op)
            2'b00: begin
                res = a + b;
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            2'b01: begin
                res = a - b;
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            2'b10:   res = a & b;
            default: res = ~b;
        endcase
        flags = {v, res[W-1], res == 0};
    endtask

    // One full transaction; stall = cycles resp_ready is held low in RESP with req_valid high.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] sh, input logic wr, input int stall);
        logic [W-1:0] exp_res;
        logic [2:0]   exp_flags;
        m_calc(op, a, m_shift(b, sh), exp_res, exp_flags);
        if (wr) m_status = exp_flags;

        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_shift = sh;
        req_wr_status = wr;
        step();
        check("busy_after_accept", busy, 1'b1);
        check("req_ready_after_accept", req_ready, 1'b0);
        req_op = 2'($urandom);
        req_b = W'($urandom);
        req_shift = 2'($urandom);
        req_wr_status = 1'($urandom);
        step();
        req_a = W'($urandom);
        check("resp_valid_early1", resp_valid, 1'b0);
        step();
        check("resp_valid_early2", resp_valid, 1'b0);
        // Acceptance edge counted as the first edge; result visible after the fourth.
        step();
        check("resp_valid", resp_valid, 1'b1);
        check("resp_data", resp_data, exp_res);
        check("status", status, m_status);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_resp_valid", resp_valid, 1'b1);
            check("stall_resp_data", resp_data, exp_res);
            check("stall_status", status, m_status);
            check("stall_req_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("resp_valid_drop", resp_valid, 1'b0);
        check("busy_drop", busy, 1'b0);
        check("resp_data_hold", resp_data, exp_res);
    endtask

    initial begin
        logic [W-1:0] exp_res;
        logic [2:0]   exp_flags;
        repeat (2) step();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_status", status, 3'b000);
        check("rst_resp_data", resp_data, 16'h0000);
        reset_n = 1'b1;
        step();

        run_op(2'b00, 16'h000A, 16'h0001, 2'b00, 1'b1, 0);
        run_op(2'b01, 16'h0005, 16'h0005, 2'b00, 1'b1, 0);
        run_op(2'b00, 16'h7FFF, 16'h0001, 2'b00, 1'b1, 0);
        run_op(2'b10, 16'h000A, 16'h0001, 2'b00, 1'b0, 5);
        check("status_kept_110", status, 3'b110);

        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom), W'($urandom), W'($urandom), 2'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)));
        end
        run_op(2'b01, 16'h8000, 16'h0001, 2'b00, 1'b1, 1);
        run_op(2'b00, 16'h7FFF, 16'h0001, 2'b00, 1'b1, 0);

        // Abort an operation in EXEC with an asynchronous reset.
        req_valid = 1'b1;
        req_op = 2'b00;
        req_a = 16'h1234;
        req_b = 16'h1111;
        req_wr_status = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        m_status = 3'b000;
        check("abort_resp_valid", resp_valid, 1'b0);
        check("abort_status", status, 3'b000);
        check("abort_busy", busy, 1'b0);
        check("abort_resp_data", resp_data, 16'h0000);
        step();
        check("abort_held_busy", busy, 1'b0);
        reset_n = 1'b1;
        #1;
        check("post_rst_req_ready", req_ready, 1'b1);
        run_op(2'b00, 16'h0002, 16'h0003, 2'b00, 1'b1, 0);
        check("post_rst_sum", resp_data, 16'h0005);

`ifdef ALU_SEQ_SHIFT_EN
        run_op(2'b11, 16'h5555, 16'h0001, 2'b01, 1'b1, 0);
        check("shift_notb", resp_data, 16'hFFFD);
        run_op(2'b00, 16'h0000, 16'h8000, 2'b11, 1'b1, 0);
        check("shift_asr", resp_data, 16'hC000);
        check("shift_asr_status", status, 3'b010);
        run_op(2'b00, 16'h0000, 16'h8000, 2'b10, 1'b1, 0);
        check("shift_lsr", resp_data, 16'h4000);
`else
        run_op(2'b11, 16'h5555, 16'h0001, 2'b01, 1'b1, 0);
        check("noshift_notb", resp_data, 16'hFFFE);
`endif
        m_calc(2'b00, 16'h0000, 16'h0000, exp_res, exp_flags);
        run_op(2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 2);
        check("zero_flag", status, {1'b0, exp_flags[1], 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
